// File: rtl/seri_uart_param_if.sv
// seri_uart_param_if: TX handshake and RX report bundle for seri_uart_param
//   gidenVeri/gidenGecerli/gidenHazir : TX word, valid, ready
//   gelenVeri/gelenGecerli            : last RX word and its one-cycle strobe
//   cerceveHatasi/pariteHatasi        : RX error flags, pulse with gelenGecerli
//   master = user side, slave = UART side
interface seri_uart_param_if #(parameter int VERI_BIT = 8);
    logic [VERI_BIT-1:0] gidenVeri;
    logic                gidenGecerli;
    logic                gidenHazir;
    logic [VERI_BIT-1:0] gelenVeri;
    logic                gelenGecerli;
    logic                cerceveHatasi;
    logic                pariteHatasi;
    modport master (
        output gidenVeri, gidenGecerli,
        input  gidenHazir, gelenVeri, gelenGecerli, cerceveHatasi, pariteHatasi
    );
    modport slave (
        input  gidenVeri, gidenGecerli,
        output gidenHazir, gelenVeri, gelenGecerli, cerceveHatasi, pariteHatasi
    );
endinterface

// File: rtl/seri_uart_param.sv
// seri_uart_param: parametrised full-duplex UART, 16x oversampled RX with framing/break detection
//   saatDarbesi : clock, rising edge      sifirlama : synchronous active-high reset
//   bus         : seri_uart_param_if.slave (TX handshake, RX word and error pulses)
//   gidenHat    : serial TX line, idle 1  gelenHat  : asynchronous serial RX line
//   mesgul      : TX or RX not idle
//   Optional parity bit is compiled in with the macro SERI_PARITE_EN.
module seri_uart_param #(
    parameter int SAAT_HZ    = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int VERI_BIT   = 8,
    parameter int DURMA_BIT  = 1,
    parameter int PARITE_TEK = 0
) (
    input  logic             saatDarbesi,
    input  logic             sifirlama,
    seri_uart_param_if.slave bus,
    output logic             gidenHat,
    input  logic             gelenHat,
    output logic             mesgul
);
    localparam int BOLME   = (SAAT_HZ + 8 * BAUD) / (16 * BAUD);
    localparam int BIT_CYC = 16 * BOLME;
    localparam int TW      = $clog2(BIT_CYC);
    localparam int KW      = BOLME > 1 ? $clog2(BOLME) : 1;
    localparam logic [TW-1:0] BIT_SON   = TW'(BIT_CYC - 1);
    localparam logic [KW-1:0] TIK_SON   = KW'(BOLME - 1);
    localparam logic [2:0]    VERI_SON  = 3'(VERI_BIT - 1);
    localparam logic [2:0]    DURMA_SON = 3'(DURMA_BIT - 1);
    localparam logic          TEK       = 1'(PARITE_TEK);

    if (BOLME < 1) begin : gBolmeKontrol
        $error("seri_uart_param: BOLME must be at least 1");
    end
    if (VERI_BIT < 5 || VERI_BIT > 8 || (DURMA_BIT != 1 && DURMA_BIT != 2) ||
        (PARITE_TEK != 0 && PARITE_TEK != 1)) begin : gParamKontrol
        $error("seri_uart_param: VERI_BIT, DURMA_BIT or PARITE_TEK out of range");
    end

    typedef enum logic [2:0] {
        BOSTA,
        BASLA,
        VERI,
`ifdef SERI_PARITE_EN
        PARITE,
`endif
        DURMA,
        KIRIK
    } durumT;

    durumT               txDurum, txDurumN, rxDurum, rxDurumN;
    logic [TW-1:0]       txSayac, txSayacN;
    logic [2:0]          txBit, txBitN, rxBit, rxBitN;
    logic [VERI_BIT-1:0] txKelime, txKelimeN, rxKaydir, rxKaydirN, gelenVeriN;
    logic                txHatN, hazirN, gecerliN, cerceveN, pariteN;
    logic                senk1, senk2, tik;
    logic [KW-1:0]       tikSayac;
    logic [3:0]          rxSayac, rxSayacN;
`ifdef SERI_PARITE_EN
    logic                rxPar, rxParN;
`endif

    assign mesgul = txDurum != BOSTA || rxDurum != BOSTA;
    assign tik    = tikSayac == TIK_SON;

    always_comb begin
        txDurumN  = txDurum;
        txSayacN  = (txDurum == BOSTA || txSayac == BIT_SON) ? '0 : txSayac + 1'b1;
        txBitN    = txBit;
        txKelimeN = txKelime;
        if (txSayac == BIT_SON) begin
            case (txDurum)
                BASLA: begin
                    txDurumN = VERI;
                    txBitN   = '0;
                end
                VERI: begin
                    txBitN = txBit == VERI_SON ? '0 : txBit + 1'b1;
`ifdef SERI_PARITE_EN
                    txDurumN = txBit == VERI_SON ? PARITE : VERI;
`else
                    txDurumN = txBit == VERI_SON ? DURMA : VERI;
`endif
                end
`ifdef SERI_PARITE_EN
                PARITE: txDurumN = DURMA;
`endif
                DURMA: begin
                    txBitN   = txBit == DURMA_SON ? '0 : txBit + 1'b1;
                    txDurumN = txBit == DURMA_SON ? BOSTA : DURMA;
                end
                default: ;
            endcase
        end
        if (bus.gidenHazir && bus.gidenGecerli) begin
            txDurumN  = BASLA;
            txSayacN  = '0;
            txBitN    = '0;
            txKelimeN = bus.gidenVeri;
        end
        // Ready already in the last cycle of the final stop bit: the next word starts with no idle gap.
        hazirN = txDurumN == BOSTA || (txDurumN == DURMA && txBitN == DURMA_SON && txSayacN == BIT_SON);
`ifdef SERI_PARITE_EN
        txHatN = txDurumN == BASLA ? 1'b0 : txDurumN == VERI ? txKelimeN[txBitN] :
                 txDurumN == PARITE ? ((^txKelimeN) ^ TEK) : 1'b1;
`else
        txHatN = txDurumN == BASLA ? 1'b0 : txDurumN == VERI ? txKelimeN[txBitN] : 1'b1;
`endif
    end

    always_ff @(posedge saatDarbesi) begin
        if (sifirlama) begin
            txDurum        <= BOSTA;
            txSayac        <= '0;
            txBit          <= '0;
            txKelime       <= '0;
            gidenHat       <= 1'b1;
            bus.gidenHazir <= 1'b0;
        end else begin
            txDurum        <= txDurumN;
            txSayac        <= txSayacN;
            txBit          <= txBitN;
            txKelime       <= txKelimeN;
            gidenHat       <= txHatN;
            bus.gidenHazir <= hazirN;
        end
    end

    always_comb begin
        rxDurumN   = rxDurum;
        rxSayacN   = rxSayac;
        rxBitN     = rxBit;
        rxKaydirN  = rxKaydir;
        gelenVeriN = bus.gelenVeri;
        gecerliN   = 1'b0;
        cerceveN   = 1'b0;
        pariteN    = 1'b0;
`ifdef SERI_PARITE_EN
        rxParN     = rxPar;
`endif
        if (rxDurum == KIRIK) begin
            rxDurumN = senk2 ? BOSTA : KIRIK;
        end else if (tik) begin
            // 4-bit tick count wraps 15 -> 0, so each sample lands 16 ticks after the previous one.
            rxSayacN = rxSayac + 1'b1;
            case (rxDurum)
                BOSTA: begin
                    rxSayacN = '0;
                    rxDurumN = senk2 ? BOSTA : BASLA;
                end
                BASLA: if (rxSayac == 4'd7) begin
                    rxSayacN = '0;
                    rxBitN   = '0;
                    rxDurumN = senk2 ? BOSTA : VERI;
                end
                VERI: if (rxSayac == 4'd15) begin
                    rxKaydirN = {senk2, rxKaydir[VERI_BIT-1:1]};
                    rxBitN    = rxBit + 1'b1;
`ifdef SERI_PARITE_EN
                    rxDurumN  = rxBit == VERI_SON ? PARITE : VERI;
`else
                    rxDurumN  = rxBit == VERI_SON ? DURMA : VERI;
`endif
                end
`ifdef SERI_PARITE_EN
                PARITE: if (rxSayac == 4'd15) begin
                    rxParN   = senk2;
                    rxDurumN = DURMA;
                end
`endif
                DURMA: if (rxSayac == 4'd15) begin
                    gelenVeriN = rxKaydir;
                    gecerliN   = 1'b1;
                    cerceveN   = !senk2;
`ifdef SERI_PARITE_EN
                    pariteN    = ((^rxKaydir) ^ rxPar) != TEK;
`endif
                    rxDurumN   = senk2 ? BOSTA : KIRIK;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge saatDarbesi) begin
        if (sifirlama) begin
            senk1             <= 1'b1;
            senk2             <= 1'b1;
            tikSayac          <= '0;
            rxDurum           <= BOSTA;
            rxSayac           <= '0;
            rxBit             <= '0;
            rxKaydir          <= '0;
            bus.gelenVeri     <= '0;
            bus.gelenGecerli  <= 1'b0;
            bus.cerceveHatasi <= 1'b0;
            bus.pariteHatasi  <= 1'b0;
`ifdef SERI_PARITE_EN
            rxPar             <= 1'b0;
`endif
        end else begin
            senk1             <= gelenHat;
            senk2             <= senk1;
            tikSayac          <= tik ? '0 : tikSayac + 1'b1;
            rxDurum           <= rxDurumN;
            rxSayac           <= rxSayacN;
            rxBit             <= rxBitN;
            rxKaydir          <= rxKaydirN;
            bus.gelenVeri     <= gelenVeriN;
            bus.gelenGecerli  <= gecerliN;
            bus.cerceveHatasi <= cerceveN;
            bus.pariteHatasi  <= pariteN;
`ifdef SERI_PARITE_EN
            rxPar             <= rxParN;
`endif
        end
    end
endmodule

// File: tb/tb_seri_uart_param.sv
// tb_seri_uart_param: directed bench for seri_uart_param at 16 MHz / 500 kbaud (32 cycles per bit)
module tb_seri_uart_param;
    localparam int BIT = 32;
`ifdef SERI_PARITE_EN
    localparam int P = 1;
    localparam logic [10:0] TX4D = 11'h49A;
`else
    localparam int P = 0;
    localparam logic [10:0] TX4D = 11'h29A;
`endif
    localparam int FRAME = (10 + P) * BIT;

    logic saatDarbesi = 1'b0;
    logic sifirlama   = 1'b1;
    logic rxSur       = 1'b1;
    logic dongu       = 1'b1;
    logic gidenHat, gelenHat, mesgul;
    int   kontrolSayisi = 0;
    int   hataSayisi    = 0;
    int   rxSay         = 0;
    logic [7:0] rxVeri [16];
    logic       rxCerceve [16];
    logic       rxParite [16];

    seri_uart_param_if #(.VERI_BIT(8)) bus();

    seri_uart_param #(
        .SAAT_HZ(16_000_000), .BAUD(500_000), .VERI_BIT(8), .DURMA_BIT(1), .PARITE_TEK(0)
    ) dut (
        .saatDarbesi(saatDarbesi),
        .sifirlama(sifirlama),
        .bus(bus),
        .gidenHat(gidenHat),
        .gelenHat(gelenHat),
        .mesgul(mesgul)
    );

    assign gelenHat = dongu ? gidenHat : rxSur;

    always #5 saatDarbesi = ~saatDarbesi;

    always @(negedge saatDarbesi) begin
        if (bus.gelenGecerli) begin
            if (rxSay < 16) begin
                rxVeri[rxSay]    = bus.gelenVeri;
                rxCerceve[rxSay] = bus.cerceveHatasi;
                rxParite[rxSay]  = bus.pariteHatasi;
            end
            rxSay++;
        end
    end

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        kontrolSayisi++;
        if (gozlenen !== beklenen) begin
            hataSayisi++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic bekleRx(input int hedef, input int sinir);
        for (int i = 0; i < sinir && rxSay < hedef; i++) @(negedge saatDarbesi);
        kontrol("rxCount", rxSay, hedef);
    endtask

    task automatic bekleBosta(input int sinir);
        for (int i = 0; i < sinir && mesgul; i++) @(negedge saatDarbesi);
        kontrol("idleWait", mesgul, 0);
    endtask

    task automatic gonder(input logic [7:0] d);
        @(negedge saatDarbesi);
        for (int i = 0; i < 2000 && !bus.gidenHazir; i++) @(negedge saatDarbesi);
        kontrol("txReadyWait", bus.gidenHazir, 1);
        bus.gidenVeri    = d;
        bus.gidenGecerli = 1'b1;
        @(posedge saatDarbesi);
        #1 bus.gidenGecerli = 1'b0;
    endtask

    task automatic hatOku(output logic [10:0] f, input int n);
        f = '0;
        for (int k = 0; k < n; k++) begin
            repeat (k == 0 ? 16 : BIT) @(negedge saatDarbesi);
            f[k] = gidenHat;
        end
    endtask

    task automatic cerceveSur(input logic [7:0] d, input logic par, input logic stop);
        @(posedge saatDarbesi);
        #1 rxSur = 1'b0;
        repeat (BIT) @(posedge saatDarbesi);
        for (int i = 0; i < 8; i++) begin
            #1 rxSur = d[i];
            repeat (BIT) @(posedge saatDarbesi);
        end
        if (P == 1) begin
            #1 rxSur = par;
            repeat (BIT) @(posedge saatDarbesi);
        end
        #1 rxSur = stop;
        repeat (BIT) @(posedge saatDarbesi);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] f;
        longint t1, t2;
        int taban;
        bus.gidenVeri    = '0;
        bus.gidenGecerli = 1'b0;
        repeat (3) @(posedge saatDarbesi);
        @(negedge saatDarbesi);
        kontrol("rstTxLine", gidenHat, 1);
        kontrol("rstReady", bus.gidenHazir, 0);
        kontrol("rstRxData", bus.gelenVeri, 0);
        kontrol("rstRxValid", bus.gelenGecerli, 0);
        kontrol("rstFrameErr", bus.cerceveHatasi, 0);
        kontrol("rstParityErr", bus.pariteHatasi, 0);
        kontrol("rstBusy", mesgul, 0);
        sifirlama = 1'b0;
        @(negedge saatDarbesi);
        kontrol("readyAfterRst", bus.gidenHazir, 1);

        gonder(8'h4D);
        hatOku(f, 10 + P);
        kontrol("txFrame4D", f, TX4D);
        bekleRx(1, 100);
        kontrol("rxData4D", rxVeri[0], 8'h4D);
        kontrol("rxFrameErr4D", rxCerceve[0], 0);
        kontrol("rxParityErr4D", rxParite[0], 0);

        taban = rxSay;
        @(negedge saatDarbesi);
        for (int i = 0; i < 2000 && !bus.gidenHazir; i++) @(negedge saatDarbesi);
        bus.gidenVeri    = 8'h55;
        bus.gidenGecerli = 1'b1;
        @(posedge saatDarbesi);
        t1 = $time;
        #1 bus.gidenVeri = 8'hAA;
        @(negedge saatDarbesi);
        for (int i = 0; i < FRAME + 50 && !bus.gidenHazir; i++) @(negedge saatDarbesi);
        @(posedge saatDarbesi);
        t2 = $time;
        #1 bus.gidenGecerli = 1'b0;
        kontrol("b2bSpacing", 32'((t2 - t1) / 10), FRAME);
        bekleRx(taban + 2, 2 * FRAME + 100);
        kontrol("b2bFirst", rxVeri[taban], 8'h55);
        kontrol("b2bSecond", rxVeri[taban + 1], 8'hAA);

        bekleBosta(FRAME);
        taban = rxSay;
        dongu = 1'b0;
        @(posedge saatDarbesi);
        #1 rxSur = 1'b0;
        repeat (8) @(posedge saatDarbesi);
        #1 rxSur = 1'b1;
        for (int i = 0; i < 20 && mesgul; i++) @(negedge saatDarbesi);
        kontrol("falseStartIdle", mesgul, 0);
        repeat (400) @(negedge saatDarbesi);
        kontrol("falseStartNoRx", rxSay, taban);

        taban = rxSay;
        cerceveSur(8'h31, 1'b1, 1'b0);
        repeat (1000) @(posedge saatDarbesi);
        #1;
        kontrol("breakOneReport", rxSay, taban + 1);
        kontrol("breakData", rxVeri[taban], 8'h31);
        kontrol("breakFrameErr", rxCerceve[taban], 1);
        kontrol("breakBusy", mesgul, 1);
        rxSur = 1'b1;
        repeat (64) @(posedge saatDarbesi);
        cerceveSur(8'h32, 1'b1, 1'b1);
        bekleRx(taban + 2, 100);
        kontrol("afterBreakData", rxVeri[taban + 1], 8'h32);
        kontrol("afterBreakFrameErr", rxCerceve[taban + 1], 0);
        kontrol("afterBreakParityErr", rxParite[taban + 1], 0);

`ifdef SERI_PARITE_EN
        dongu = 1'b1;
        taban = rxSay;
        gonder(8'h07);
        hatOku(f, 11);
        kontrol("txParityBit07", f[9], 1);
        bekleRx(taban + 1, 100);
        kontrol("loopParityOk07", rxParite[taban], 0);
        dongu = 1'b0;
        cerceveSur(8'h07, 1'b0, 1'b1);
        bekleRx(taban + 2, 100);
        kontrol("badParityData", rxVeri[taban + 1], 8'h07);
        kontrol("badParityErr", rxParite[taban + 1], 1);
`endif

        dongu = 1'b1;
        bekleBosta(FRAME);
        taban = rxSay;
        gonder(8'hA5);
        repeat (140) @(negedge saatDarbesi);
        kontrol("txBit3BeforeRst", gidenHat, 0);
        sifirlama = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge saatDarbesi);
            kontrol("midRstTxLine", gidenHat, 1);
            kontrol("midRstReady", bus.gidenHazir, 0);
        end
        sifirlama = 1'b0;
        @(negedge saatDarbesi);
        kontrol("readyAfterMidRst", bus.gidenHazir, 1);
        kontrol("busyAfterMidRst", mesgul, 0);
        repeat (400) @(negedge saatDarbesi);
        kontrol("noRxAfterMidRst", rxSay, taban);

        $display("Simulation finished: %0d checks, %0d errors", kontrolSayisi, hataSayisi);
        $finish;
    end
endmodule
